// File: rtl/scroller_pkg.sv
// scroller_pkg: shared constants and types for the scroller digit-load path
package scroller_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_CR = 8'h0D;

    typedef enum logic [1:0] {
        COLLECT,
        BURST,
        GAP
    } feeder_state_t;

endpackage

// File: rtl/scroller_feeder_if.sv
// scroller_feeder_if: character-source handshake plus scroller write port
interface scroller_feeder_if;
    import scroller_pkg::*;

    logic [7:0]         iASCII;
    logic               iVALID;
    logic               oREADY;
    logic               oRD;
    logic [DIGIT_W-1:0] oDEC;
    logic               oBUSY;

    modport master (output iASCII, iVALID, input oREADY, oRD, oDEC, oBUSY);
    modport slave  (input iASCII, iVALID, output oREADY, oRD, oDEC, oBUSY);

endinterface

// File: rtl/scroller_feeder_ascii_to_dec.sv
// ascii_to_dec: maps an ASCII byte to a 4-bit display code; SCR_TERM_EN adds the CR terminator flag
module ascii_to_dec
    import scroller_pkg::*;
(
    input  logic [7:0]         ascii,
`ifdef SCR_TERM_EN
    output logic               is_term,
`endif
    output logic [DIGIT_W-1:0] code
);

    // digits pass through as their value, everything else shows blank
    always_comb begin
        code = (ascii >= ASC_0 && ascii <= ASC_9) ? DIGIT_W'(ascii - ASC_0) : BLANK;
`ifdef SCR_TERM_EN
        is_term = (ascii == ASC_CR);
`endif
    end

endmodule

// File: rtl/scroller_feeder.sv
// scroller_feeder: groups ASCII digits in threes and writes them to the scroller as strobed bursts
// Optional feature: define SCR_TERM_EN to let CR flush a partial group.
module scroller_feeder
    import scroller_pkg::*;
#(
    parameter int DIGITS     = 3,
    parameter int GAP_CYCLES = 2
)(
    input  logic               clk,
    input  logic               rst,
    scroller_feeder_if.slave   bus
);

    feeder_state_t      state_q, state_n;
    logic [1:0]         cnt_q, cnt_n;
    logic [3:0]         gcnt_q, gcnt_n;
    logic [1:0]         idx_q, idx_n;
    logic [DIGIT_W-1:0] dig_q [DIGITS];
    logic [DIGIT_W-1:0] dig_n [DIGITS];
    logic [DIGIT_W-1:0] code, dec_n;
    logic               rd_n, rdy_n, busy_n, xfer, term;

`ifdef SCR_TERM_EN
    logic is_term;

    ascii_to_dec u_map (.ascii(bus.iASCII), .is_term(is_term), .code(code));

    assign term = is_term;
`else
    ascii_to_dec u_map (.ascii(bus.iASCII), .code(code));

    assign term = 1'b0;
`endif

    assign xfer = bus.oREADY && bus.iVALID;

    // next state, buffer update and next registered outputs
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        gcnt_n  = gcnt_q;
        idx_n   = idx_q;
        dig_n   = dig_q;
        case (state_q)
            COLLECT: begin
                if (xfer && term) begin
                    if (idx_q != 2'd0) begin
                        state_n = BURST;
                        cnt_n   = 2'd0;
                    end
                end else if (xfer) begin
                    dig_n[idx_q] = code;
                    idx_n        = idx_q + 2'd1;
                    if (idx_q == 2'(DIGITS - 1)) begin
                        state_n = BURST;
                        cnt_n   = 2'd0;
                    end
                end
            end
            BURST: begin
                cnt_n = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_n = GAP;
                    gcnt_n  = 4'd0;
                end
            end
            GAP: begin
                gcnt_n = gcnt_q + 4'd1;
                if (gcnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_n = COLLECT;
                    idx_n   = 2'd0;
                    dig_n   = '{default: BLANK};
                end
            end
            default: state_n = COLLECT;
        endcase
        rd_n   = (state_n == BURST) && (cnt_n != 2'd3);
        dec_n  = (state_n == BURST && cnt_n != 2'd0) ? dig_n[cnt_n - 2'd1] : BLANK;
        rdy_n  = (state_n == COLLECT);
        busy_n = !rdy_n;
    end

    // state, buffer and registered outputs; reset aborts any burst in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= COLLECT;
            cnt_q      <= 2'd0;
            gcnt_q     <= 4'd0;
            idx_q      <= 2'd0;
            dig_q      <= '{default: BLANK};
            bus.oRD    <= 1'b0;
            bus.oDEC   <= BLANK;
            bus.oREADY <= 1'b0;
            bus.oBUSY  <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            gcnt_q     <= gcnt_n;
            idx_q      <= idx_n;
            dig_q      <= dig_n;
            bus.oRD    <= rd_n;
            bus.oDEC   <= dec_n;
            bus.oREADY <= rdy_n;
            bus.oBUSY  <= busy_n;
        end
    end

endmodule

// File: tb/tb_scroller_feeder.sv
// tb_scroller_feeder: table-driven and scoreboard bench for scroller_feeder (honours SCR_TERM_EN)
module tb_scroller_feeder;
    import scroller_pkg::*;

    localparam int GAP = 2;

    typedef struct {
        logic [7:0] ch;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    vec_t tbl [12];
    logic [3:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    logic rd_prev = 1'b0;
    int hi_run = 0;
    int lo_run = 100;

    always #5 clk = ~clk;

    scroller_feeder_if bus ();

    scroller_feeder #(.DIGITS(3), .GAP_CYCLES(GAP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] ch, output int waited);
        bit ok = 0;
        waited = 0;
        bus.iASCII = ch;
        bus.iVALID = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.oREADY;
            @(posedge clk);
            #1;
            if (!ok) waited++;
        end
        bus.iVALID = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send_exp(input logic [7:0] ch, input logic [3:0] exp);
        int w;
        exp_q.push_back(exp);
        send(ch, w);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || bus.oBUSY); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_left", exp_q.size(), 0);
        check("idle_busy", bus.oBUSY, 0);
        check("idle_ready", bus.oREADY, 1);
    endtask

    // scroller model: a strobe seen last cycle means DEC is sampled now
    always @(negedge clk) begin
        if (!rst) begin
            rd_prev = 1'b0;
            hi_run  = 0;
            lo_run  = 100;
        end else begin
            if (rd_prev) begin
                if (exp_q.size() == 0) check("unexpected_digit", 1, 0);
                else check("digit", bus.oDEC, exp_q.pop_front());
            end else begin
                check("dec_idle", bus.oDEC, BLANK);
            end
            if (bus.oRD && !rd_prev) begin
                check("gap_low_cycles_ok", lo_run >= GAP + 1, 1);
                hi_run = 0;
            end
            if (!bus.oRD && rd_prev) begin
                check("strobe_len", hi_run, 3);
                lo_run = 0;
            end
            if (bus.oRD) hi_run++;
            else lo_run++;
            rd_prev = bus.oRD;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        tbl = '{
            '{8'h31, 4'h1}, '{8'h32, 4'h2}, '{8'h33, 4'h3},
            '{8'h37, 4'h7}, '{8'h41, 4'hF}, '{8'h20, 4'hF},
            '{8'h30, 4'h0}, '{8'h39, 4'h9}, '{8'h2F, 4'hF},
            '{8'h3A, 4'hF}, '{8'h35, 4'h5}, '{8'hFF, 4'hF}
        };
        bus.iASCII = 8'h00;
        bus.iVALID = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rd", bus.oRD, 0);
        check("rst_dec", bus.oDEC, BLANK);
        check("rst_ready", bus.oREADY, 0);
        check("rst_busy", bus.oBUSY, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("release_ready", bus.oREADY, 1);
        check("release_busy", bus.oBUSY, 0);

        for (int i = 0; i < 12; i++) send_exp(tbl[i].ch, tbl[i].exp);
        wait_idle();

        send_exp("4", 4'h4);
        send_exp("5", 4'h5);
        send_exp("6", 4'h6);
        check("b0_rd", bus.oRD, 1);
        check("b0_ready", bus.oREADY, 0);
        check("b0_busy", bus.oBUSY, 1);
        exp_q.push_back(4'h8);
        send("8", w);
        check("bp_wait_cycles", w, 4 + GAP);
        send_exp("9", 4'h9);
        send_exp("0", 4'h0);
        wait_idle();

        send_exp("9", 4'h9);
`ifdef SCR_TERM_EN
        exp_q.push_back(BLANK);
        exp_q.push_back(BLANK);
        send(ASC_CR, w);
        check("term_burst_rd", bus.oRD, 1);
        wait_idle();
        send(ASC_CR, w);
        repeat (3) @(posedge clk);
        #1;
        check("term_idx0_busy", bus.oBUSY, 0);
        check("term_idx0_rd", bus.oRD, 0);
        send_exp("1", 4'h1);
        send_exp("2", 4'h2);
        send_exp("3", 4'h3);
        wait_idle();
`else
        send_exp(ASC_CR, BLANK);
        repeat (5) @(posedge clk);
        #1;
        check("cr_wait_busy", bus.oBUSY, 0);
        check("cr_wait_ready", bus.oREADY, 1);
        send_exp("4", 4'h4);
        wait_idle();
`endif

        send_exp("1", 4'h1);
        send_exp("2", 4'h2);
        send_exp("3", 4'h3);
        @(posedge clk);
        #1;
        check("b1_rd", bus.oRD, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rd", bus.oRD, 0);
        check("midrst_dec", bus.oDEC, BLANK);
        check("midrst_ready", bus.oREADY, 0);
        check("midrst_busy", bus.oBUSY, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_release_ready", bus.oREADY, 1);
        send_exp("5", 4'h5);
        send_exp("6", 4'h6);
        send_exp("7", 4'h7);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
